// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter. Sends one parallel word per frame:
// a start bit, DATA_BITS data bits LSB first, an optional parity bit,
// and STOP_BITS stop bits. Each bit is held for CLKS_PER_BIT clocks.
// The serial line is driven straight from a register, so it cannot glitch.
module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,   // 0 = none, 1 = odd, 2 = even
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           r_state;
  logic [BAUD_W-1:0]    r_baud;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_tx;
  logic                 r_done;

  logic [2:0]           w_state_next;
  logic [BAUD_W-1:0]    w_baud_next;
  logic [BIT_W-1:0]     w_bit_next;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 w_parity_next;
  logic                 w_tx_next;
  logic                 w_done_next;

  logic                 w_baud_wrap;
  logic                 w_parity_in;
  logic                 w_idle;

  assign w_idle      = (r_state == S_IDLE);
  assign w_baud_wrap = (r_baud == BAUD_LAST);

  // Parity is taken from the word at the moment of acceptance; the latched
  // copy is what goes on the line, so later changes on tx_data are harmless.
  assign w_parity_in = (PARITY == 1) ? ~(^tx_data) : (^tx_data);

  // Next-state logic: the line level for the next bit is computed together
  // with the state change so that tx can be a plain register.
  always_comb begin
    w_state_next  = r_state;
    w_baud_next   = r_baud;
    w_bit_next    = r_bit;
    w_shift_next  = r_shift;
    w_parity_next = r_parity;
    w_tx_next     = r_tx;
    w_done_next   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (tx_valid) begin
          w_shift_next  = tx_data;
          w_parity_next = w_parity_in;
          w_baud_next   = '0;
          w_bit_next    = '0;
          w_tx_next     = 1'b0;
          w_state_next  = S_START;
        end
      end

      S_START: begin
        if (w_baud_wrap) begin
          w_baud_next  = '0;
          w_tx_next    = r_shift[0];
          w_state_next = S_DATA;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end

      S_DATA: begin
        if (w_baud_wrap) begin
          w_baud_next  = '0;
          w_shift_next = r_shift >> 1;
          if (r_bit == DATA_LAST) begin
            // The bit counter is reused to count stop bits.
            w_bit_next = '0;
            if (PARITY != 0) begin
              w_tx_next    = r_parity;
              w_state_next = S_PARITY;
            end else begin
              w_tx_next    = 1'b1;
              w_state_next = S_STOP;
            end
          end else begin
            w_bit_next = r_bit + 1'b1;
            w_tx_next  = r_shift[1];
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end

      S_PARITY: begin
        if (w_baud_wrap) begin
          w_baud_next  = '0;
          w_tx_next    = 1'b1;
          w_state_next = S_STOP;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end

      S_STOP: begin
        if (w_baud_wrap) begin
          w_baud_next = '0;
          if (r_bit == STOP_LAST) begin
            w_bit_next   = '0;
            w_done_next  = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_bit_next = r_bit + 1'b1;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end

      default: begin
        w_tx_next    = 1'b1;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State and counter registers; reset drops any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
    end
  end

  // Data path registers: shift register and latched parity bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift  <= '0;
      r_parity <= 1'b0;
    end else begin
      r_shift  <= w_shift_next;
      r_parity <= w_parity_next;
    end
  end

  // Output registers: the line returns to idle-high as soon as reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx   <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_tx   <= w_tx_next;
      r_done <= w_done_next;
    end
  end

  assign tx       = r_tx;
  assign tx_done  = r_done;
  assign tx_ready = w_idle;
  assign busy     = ~w_idle;

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that serialises one parallel word per frame: start bit, 5–9 data bits LSB first, optional parity, then 1 or 2 stop bits. Each bit is held for a programmable number of clock cycles. Words are accepted through a valid/ready handshake, and the block reports frame completion with a single-cycle pulse. It sits between the system-side producer (FIFO or control FSM) and the serial line pin, in the same clock domain as the producer.

## Interface
- DATA_BITS, 8, data bits per frame; legal 5–9
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal ≥ 2
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame; legal 1 or 2
- clk  input  1  rising-edge clock; sole clock
- rst_n  input  1  asynchronous, active-low reset
- tx_data  input  DATA_BITS  word to send; sampled only on handshake
- tx_valid  input  1  producer has a word on tx_data
- tx_ready  output  1  block can accept a word; high only in IDLE
- tx  output  1  serial line; registered; idle level 1
- busy  output  1  frame in progress (any state other than IDLE)
- tx_done  output  1  one-cycle pulse when the last stop bit completes

## Operation
- States: IDLE → START → DATA → PARITY (skipped when PARITY = 0) → STOP → IDLE.
- IDLE behaviour:
  - tx = 1, tx_ready = 1, busy = 0.
  - On a clock edge with tx_valid && tx_ready: latch tx_data into the shift register, compute the parity bit, clear bit/baud counters, go to START.
- Baud counter runs 0..CLKS_PER_BIT-1. Each bit is held exactly CLKS_PER_BIT cycles. The state or bit advances when the counter wraps.
- START: tx = 0.
- DATA: tx = shift[0]. Shift right once per bit. Bit counter runs 0..DATA_BITS-1, then the FSM leaves DATA.
- Parity bit:
  - Even: XOR of the latched word.
  - Odd: inverted XOR of the latched word.
  - Computed from the latched copy, never from the live tx_data.
- STOP: tx = 1 for STOP_BITS × CLKS_PER_BIT cycles. Then go to IDLE and pulse tx_done.
- tx_valid outside IDLE is ignored. Changes on tx_data after acceptance have no effect on the frame in flight.
- Counter widths: baud counter is $clog2(CLKS_PER_BIT) bits; bit counter is $clog2(DATA_BITS+1) bits. No overflow is possible within legal parameters.
- Reset values: tx = 1, tx_ready = 1, busy = 0, tx_done = 0, state = IDLE.
- Reset mid-frame: the line returns to 1 immediately (asynchronous). The frame is discarded, no tx_done is issued, and the next accepted word starts a fresh frame.

## Timing
- Frame length F = 1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS bits.
- Handshake sampled at edge E0. From E0 to E(C), tx = 0 (start bit), where C = CLKS_PER_BIT.
- Bit k of the frame (start = bit 0) is driven from edge E(k·C) until edge E((k+1)·C).
- At E(F·C):
  - state = IDLE, tx_done = 1 for exactly that one cycle.
  - tx_ready = 1 and busy = 0 in the same cycle.
- Back-to-back operation: with tx_valid held high, the next word is accepted at E(F·C+1). The effective last stop bit is therefore C+1 cycles long. No start bit ever begins without at least C+1 high cycles before it.
- Throughput: one frame per F·C+1 cycles.
- tx_done and tx_ready are never high together except in the single cycle of the tx_done pulse.

## Test plan
- Default 8N1, C = 16, send 0xA5:
  - tx = 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles.
  - tx_done pulses once, 160 cycles after the handshake edge.
- PARITY = 2, send 0x07 → parity bit 1. PARITY = 1, send 0x07 → parity bit 0. Frame is 11 bits (176 cycles at C = 16).
- DATA_BITS = 7, STOP_BITS = 2, C = 4, send 0x55:
  - tx = 0,1,0,1,0,1,0,1,1,1, each level 4 cycles.
  - tx_done 40 cycles after the handshake edge.
- Back-to-back: tx_valid held high with 0x12 then 0x34 → second handshake exactly 1 cycle after the first tx_done. Both frames decode correctly. Words presented while busy = 1 are not consumed.
- Reset mid-frame: assert rst_n = 0 during data bit 3 → tx = 1 immediately, no tx_done. After release, 0x3C sends a clean full frame.
- C = 2 stress: send 0xFF then 0x00 → every bit held exactly 2 cycles, with no glitch on tx at bit boundaries.
